// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall/bubble statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module ex_mem_pipe_stage #(
    parameter int unsigned DBITS               = 32,
    parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
    parameter int unsigned OPBITS              = 4,
    parameter int unsigned STAT_BITS           = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,

    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OPBITS-1:0]              in_func,
    input  logic [OPBITS-1:0]              in_op,
    input  logic [DBITS-1:0]               in_regData2,
    input  logic [DBITS-1:0]               in_intermediateResult,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rs2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] in_rd,
    input  logic                           in_ME_mux_sel,
    input  logic                           in_wrReg,
    input  logic                           in_wrMem,

    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OPBITS-1:0]              out_func,
    output logic [OPBITS-1:0]              out_op,
    output logic [DBITS-1:0]               out_regData2,
    output logic [DBITS-1:0]               out_intermediateResult,
    output logic [REG_INDEX_BIT_WIDTH-1:0] out_rs2,
    output logic [REG_INDEX_BIT_WIDTH-1:0] out_rd,
    output logic                           out_ME_mux_sel,
    output logic                           out_wrReg,
    output logic                           out_wrMem
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_BITS-1:0]           stall_cnt,
    output logic [STAT_BITS-1:0]           bubble_cnt
`endif
);

    typedef struct packed {
        logic [OPBITS-1:0]              func;
        logic [OPBITS-1:0]              op;
        logic [DBITS-1:0]               regData2;
        logic [DBITS-1:0]               intermediateResult;
        logic [REG_INDEX_BIT_WIDTH-1:0] rs2;
        logic [REG_INDEX_BIT_WIDTH-1:0] rd;
        logic                           ME_mux_sel;
        logic                           wrReg;
        logic                           wrMem;
    } entry_t;

    generate
        if (STAT_BITS == 0) begin : g_stat_bits_invalid
            $error("STAT_BITS must be at least 1");
        end
    endgenerate

    entry_t in_entry;
    entry_t m_q;
    entry_t s_q;
    logic   m_valid;
    logic   s_valid;
    logic   accept;
    logic   m_free;

    always_comb begin
        in_entry = '{
            func:               in_func,
            op:                 in_op,
            regData2:           in_regData2,
            intermediateResult: in_intermediateResult,
            rs2:                in_rs2,
            rd:                 in_rd,
            ME_mux_sel:         in_ME_mux_sel,
            wrReg:              in_wrReg,
            wrMem:              in_wrMem
        };
    end

    assign in_ready = !s_valid;
    assign accept   = in_valid & in_ready;
    // M is free when empty or when its entry leaves this cycle
    assign m_free   = !m_valid | out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else if (flush) begin
            // data registers keep their contents so out_* stays stable while invalid
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                m_q     <= s_q;
                m_valid <= 1'b1;
                s_valid <= accept;
                if (accept) begin
                    s_q <= in_entry;
                end
            end else begin
                m_valid <= accept;
                if (accept) begin
                    m_q <= in_entry;
                end
            end
        end else if (accept) begin
            s_q     <= in_entry;
            s_valid <= 1'b1;
        end
    end

    assign out_valid              = m_valid;
    assign out_func               = m_q.func;
    assign out_op                 = m_q.op;
    assign out_regData2           = m_q.regData2;
    assign out_intermediateResult = m_q.intermediateResult;
    assign out_rs2                = m_q.rs2;
    assign out_rd                 = m_q.rd;
    assign out_ME_mux_sel         = m_q.ME_mux_sel;
    assign out_wrReg              = m_q.wrReg & m_valid;
    assign out_wrMem              = m_q.wrMem & m_valid;

`ifdef PIPE_STAGE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (m_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!m_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
